// File: rtl/motion_compensator.sv
// motion_compensator: fetches the displaced 16x16 block, streams
// {pred_pixel, residual} beats and recomputes the saturating SAD.
// Ports: clock/reset, go/motionX/motionY/BestDist start,
// AddressR/AddressS + R/S memory reads, out_* stream, busy/done/sad/sad_match.
module motion_compensator #(
  parameter int X_BIAS = 8,
  parameter int Y_BIAS = 9,
  parameter int BLK    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  input  logic [7:0] BestDist,
  output logic [7:0] AddressR,
  output logic [9:0] AddressS,
  input  logic [7:0] R,
  input  logic [7:0] S,
  output logic [7:0] pred_pixel,
  output logic [8:0] residual,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic [7:0] sad,
  output logic       sad_match
);

  localparam logic [7:0] LAST = 8'(BLK * BLK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t     state_q;
  logic [7:0] idx_q;
  logic [3:0] col_off_q;
  logic [3:0] row_off_q;
  logic [7:0] best_q;
  logic [7:0] pred_q;
  logic [8:0] res_q;
  logic       valid_q;
  logic       last_q;
  logic       done_q;
  logic [7:0] sad_q;
  logic       match_q;

  logic       active;
  logic       load;
  logic [4:0] row_sum;
  logic [4:0] col_sum;
  logic [8:0] res_d;
  logic [8:0] abs_d;
  logic [9:0] sum_d;
  logic [7:0] sad_d;

  assign active  = (state_q == RUN) || (state_q == DRAIN);
  assign load    = !valid_q || out_ready;
  assign row_sum = {1'b0, row_off_q} + {1'b0, idx_q[7:4]};
  assign col_sum = {1'b0, col_off_q} + {1'b0, idx_q[3:0]};

  // col_sum never exceeds 30, so row*32+col is a plain concat
  assign AddressR = active ? idx_q : 8'd0;
  assign AddressS = active ? {row_sum, col_sum} : 10'd0;

  assign res_d = {1'b0, R} - {1'b0, S};
  assign abs_d = res_d[8] ? (9'd0 - res_d) : res_d;
  assign sum_d = {2'b00, sad_q} + {1'b0, abs_d};
  assign sad_d = (sum_d > 10'd255) ? 8'hFF : sum_d[7:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 8'd0;
      col_off_q <= 4'd0;
      row_off_q <= 4'd0;
      best_q    <= 8'd0;
      pred_q    <= 8'd0;
      res_q     <= 9'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      sad_q     <= 8'd0;
      match_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            col_off_q <= motionX + 4'(X_BIAS);
            row_off_q <= motionY + 4'(Y_BIAS);
            best_q    <= BestDist;
            idx_q     <= 8'd0;
            sad_q     <= 8'd0;
            match_q   <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            pred_q  <= S;
            res_q   <= res_d;
            valid_q <= 1'b1;
            last_q  <= (idx_q == LAST);
            sad_q   <= sad_d;
            idx_q   <= idx_q + 8'd1;
            if (idx_q == LAST) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (sad_q == best_q);
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pred_pixel = pred_q;
  assign residual   = res_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign sad        = sad_q;
  assign sad_match  = match_q;

endmodule

// File: tb/tb_motion_compensator.sv
// tb_motion_compensator: random memories, scoreboard of expected beats
// built from a block-level reference model, decoupled monitor.
module tb_motion_compensator;

  logic       clock;
  logic       reset;
  logic       go;
  logic [3:0] motionX;
  logic [3:0] motionY;
  logic [7:0] BestDist;
  logic [7:0] AddressR;
  logic [9:0] AddressS;
  logic [7:0] R;
  logic [7:0] S;
  logic [7:0] pred_pixel;
  logic [8:0] residual;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [7:0] sad;
  logic       sad_match;

  logic [7:0] rom_r [256];
  logic [7:0] rom_s [1024];

  assign R = rom_r[AddressR];
  assign S = rom_s[AddressS];

  motion_compensator dut (
    .clock(clock), .reset(reset), .go(go),
    .motionX(motionX), .motionY(motionY), .BestDist(BestDist),
    .AddressR(AddressR), .AddressS(AddressS), .R(R), .S(S),
    .pred_pixel(pred_pixel), .residual(residual),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .sad(sad), .sad_match(sad_match)
  );

  typedef struct packed {
    logic [7:0] p;
    logic [8:0] r;
    logic       l;
  } beat_t;

  beat_t      bq[$];
  logic [8:0] sq[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int hs_cnt = 0;
  logic prev_done = 1'b0;
  logic rdy_rand = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_addr(input int mx, input int my, input int i);
    int co, ro;
    co = (mx + 8) % 16;
    ro = (my + 9) % 16;
    return (ro + i / 16) * 32 + co + i % 16;
  endfunction

  task automatic push_block(input int mx, input int my, input int best);
    int s, d, tot, sv;
    beat_t e;
    tot = 0;
    for (int i = 0; i < 256; i++) begin
      s = int'(rom_s[exp_addr(mx, my, i)]);
      d = int'(rom_r[i]) - s;
      tot += (d < 0) ? -d : d;
      e.p = 8'(s);
      e.r = d[8:0];
      e.l = (i == 255);
      bq.push_back(e);
    end
    sv = (tot > 255) ? 255 : tot;
    sq.push_back({(sv == best), 8'(sv)});
  endtask

  task automatic start(input int mx, input int my, input int best);
    motionX  = 4'(mx);
    motionY  = 4'(my);
    BestDist = 8'(best);
    hs_cnt   = 0;
    push_block(mx, my, best);
    go = 1'b1;
    @(posedge clock);
    #1 go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_seen;
    for (int k = 0; k < budget && done_seen == d0; k++) begin
      @(posedge clock);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("done_reached", (done_seen != d0), 1);
    chk("hs_total", hs_cnt, 256);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) rom_r[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) rom_s[i] = 8'($urandom);
  endtask

  // monitor: one comparison set per accepted beat and per done pulse
  always @(negedge clock) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual beat required none");
        end else begin
          beat_t e;
          e = bq.pop_front();
          chk("pred", pred_pixel, e.p);
          chk("resid", residual, e.r);
          chk("last", out_last, e.l);
        end
      end
      if (done) begin
        done_seen++;
        chk("beats_left", bq.size(), 0);
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual 1 required 0");
        end else begin
          logic [8:0] x;
          x = sq.pop_front();
          chk("sad", sad, x[7:0]);
          chk("sad_match", sad_match, x[8]);
        end
        chk("done_width", prev_done, 0);
      end
      prev_done = done;
    end
  end

  initial begin
    int mx, my, d0;
    reset = 1'b0;
    go = 1'b1;
    out_ready = 1'b1;
    motionX = 4'd0;
    motionY = 4'd0;
    BestDist = 8'd0;
    fill_rand();
    repeat (3) begin
      @(negedge clock);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addrS", AddressS, 0);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    go = 1'b0;

    // zero offset, S window equals R
    for (int i = 0; i < 256; i++) rom_s[(i / 16) * 32 + i % 16] = rom_r[i];
    start(8, 7, 0);
    @(negedge clock);
    chk("zero_addrS0", AddressS, 0);
    chk("zero_busy", busy, 1);
    wait_done(600);

    // max offset addressing
    fill_rand();
    start(7, 6, $urandom_range(0, 255));
    for (int k = 0; k < 256; k++) begin
      @(negedge clock);
      if (k == 0) chk("max_addr0", AddressS, 495);
      if (k == 16) chk("max_addr16", AddressS, 527);
      if (k == 255) chk("max_addr255", AddressS, 990);
    end
    wait_done(600);

    // sign and saturation
    for (int i = 0; i < 256; i++) rom_r[i] = 8'd0;
    for (int i = 0; i < 1024; i++) rom_s[i] = 8'd200;
    start(3, 11, 255);
    wait_done(600);
    start(12, 2, 254);
    wait_done(600);

    // backpressure on beat 10, go ignored while busy
    fill_rand();
    mx = $urandom_range(0, 15);
    my = $urandom_range(0, 15);
    start(mx, my, $urandom_range(0, 255));
    repeat (11) @(posedge clock);
    #1 out_ready = 1'b0;
    go = 1'b1;
    motionX = 4'(mx + 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_pred", pred_pixel, rom_s[exp_addr(mx, my, 10)]);
      chk("stall_res", residual,
          9'({1'b0, rom_r[10]} - {1'b0, rom_s[exp_addr(mx, my, 10)]}));
      chk("stall_addrS", AddressS, exp_addr(mx, my, 11));
      chk("stall_addrR", AddressR, 11);
      @(posedge clock);
      #1 go = 1'b0;
    end
    out_ready = 1'b1;
    wait_done(600);

    // reset while beat 100 is presented
    fill_rand();
    start($urandom_range(0, 15), $urandom_range(0, 15), 0);
    repeat (101) @(posedge clock);
    #1 reset = 1'b0;
    bq.delete();
    sq.delete();
    d0 = done_seen;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (6) @(posedge clock);
    #1;
    chk("mid_rst_nodone", done_seen, d0);
    start($urandom_range(0, 15), $urandom_range(0, 15), 0);
    @(negedge clock);
    chk("restart_addrR", AddressR, 0);
    chk("restart_busy", busy, 1);
    wait_done(600);

    // random blocks with random backpressure
    rdy_rand = 1'b1;
    for (int b = 0; b < 3; b++) begin
      fill_rand();
      start($urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 255));
      wait_done(2500);
    end
    rdy_rand = 1'b0;

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
